// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates the single CSR port between pipeline
// CSR instructions and multi-cycle exception/interrupt/mret update sequences.
module riscv_trap_ctrl #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exc_valid,
    input  logic [3:0]             exc_cause,
    input  logic [WORD_LENGTH-1:0] exc_pc,
    input  logic [WORD_LENGTH-1:0] exc_tval,
    input  logic                   mret_valid,
    input  logic                   irq_ext,
    input  logic [WORD_LENGTH-1:0] cur_pc,
    input  logic                   pipe_csr_we,
    input  logic [WORD_LENGTH-1:0] pipe_csr_addr,
    input  logic [WORD_LENGTH-1:0] pipe_csr_wdata,
    output logic [WORD_LENGTH-1:0] pipe_csr_rdata,
    output logic                   csr_write_en,
    output logic [WORD_LENGTH-1:0] csr_addr,
    output logic [WORD_LENGTH-1:0] csr_data,
    input  logic [WORD_LENGTH-1:0] csr_rdata,
    output logic                   stall,
    output logic                   redirect_valid,
    output logic [WORD_LENGTH-1:0] redirect_pc
);

    // state   | meaning
    // IDLE    | pass-through of pipeline CSR traffic, watching for events
    // T_EPC   | trap: write mepc
    // T_CAUSE | trap: write mcause
    // T_TVAL  | trap: write mtval
    // T_STAT  | trap: mstatus read-modify-write (MPIE<-MIE, MIE<-0, MPP<-3)
    // T_VEC   | trap: read mtvec, redirect to handler
    // R_STAT  | mret: mstatus read-modify-write (MIE<-MPIE, MPIE<-1, MPP<-3)
    // R_EPC   | mret: read mepc, redirect to return address
    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC, R_STAT, R_EPC
    } state_t;

    localparam logic [WORD_LENGTH-1:0] ADDR_MSTATUS = WORD_LENGTH'(32'h300);
    localparam logic [WORD_LENGTH-1:0] ADDR_MTVEC   = WORD_LENGTH'(32'h305);
    localparam logic [WORD_LENGTH-1:0] ADDR_MEPC    = WORD_LENGTH'(32'h341);
    localparam logic [WORD_LENGTH-1:0] ADDR_MCAUSE  = WORD_LENGTH'(32'h342);
    localparam logic [WORD_LENGTH-1:0] ADDR_MTVAL   = WORD_LENGTH'(32'h343);
    localparam logic [WORD_LENGTH-1:0] CAUSE_MEI    = {1'b1, {(WORD_LENGTH-5){1'b0}}, 4'hB};
    localparam logic [WORD_LENGTH-1:0] VEC_OFFSET   = WORD_LENGTH'(44);

    state_t                 state_q, state_d;
    logic                   mie_q, mie_d;
    logic                   irq_q, irq_d;
    logic [WORD_LENGTH-1:0] epc_q, epc_d;
    logic [WORD_LENGTH-1:0] cause_q, cause_d;
    logic [WORD_LENGTH-1:0] tval_q, tval_d;
    logic [WORD_LENGTH-1:0] redirect_pc_q, redirect_pc_d;

    logic                   we_c;
    logic                   stall_c;
    logic                   redir_c;
    logic                   irq_take;
    logic [WORD_LENGTH-1:0] mstatus_upd;
    logic [WORD_LENGTH-1:0] base;

    assign irq_take = irq_ext && mie_q && !pipe_csr_we;
    assign base     = {csr_rdata[WORD_LENGTH-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        mie_d         = mie_q;
        irq_d         = irq_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        tval_d        = tval_q;
        redirect_pc_d = redirect_pc_q;
        we_c          = 1'b0;
        stall_c       = 1'b1;
        redir_c       = 1'b0;
        csr_addr      = pipe_csr_addr;
        csr_data      = pipe_csr_wdata;
        mstatus_upd   = csr_rdata;
        case (state_q)
            IDLE: begin
                stall_c = 1'b0;
                we_c    = pipe_csr_we;
                if (exc_valid) begin
                    stall_c = 1'b1;
                    we_c    = 1'b0;
                    epc_d   = exc_pc;
                    cause_d = {{(WORD_LENGTH-4){1'b0}}, exc_cause};
                    tval_d  = exc_tval;
                    irq_d   = 1'b0;
                    state_d = T_EPC;
                end else if (mret_valid) begin
                    stall_c = 1'b1;
                    we_c    = 1'b0;
                    state_d = R_STAT;
                end else if (irq_take) begin
                    stall_c = 1'b1;
                    epc_d   = cur_pc;
                    cause_d = CAUSE_MEI;
                    tval_d  = '0;
                    irq_d   = 1'b1;
                    state_d = T_EPC;
                end else if (pipe_csr_we && pipe_csr_addr == ADDR_MSTATUS) begin
                    mie_d = pipe_csr_wdata[3];
                end
            end
            T_EPC: begin
                we_c     = 1'b1;
                csr_addr = ADDR_MEPC;
                csr_data = epc_q;
                state_d  = T_CAUSE;
            end
            T_CAUSE: begin
                we_c     = 1'b1;
                csr_addr = ADDR_MCAUSE;
                csr_data = cause_q;
                state_d  = T_TVAL;
            end
            T_TVAL: begin
                we_c     = 1'b1;
                csr_addr = ADDR_MTVAL;
                csr_data = tval_q;
                state_d  = T_STAT;
            end
            T_STAT: begin
                mstatus_upd[7]     = csr_rdata[3];
                mstatus_upd[3]     = 1'b0;
                mstatus_upd[12:11] = 2'b11;
                we_c     = 1'b1;
                csr_addr = ADDR_MSTATUS;
                csr_data = mstatus_upd;
                mie_d    = 1'b0;
                state_d  = T_VEC;
            end
            T_VEC: begin
                csr_addr = ADDR_MTVEC;
                csr_data = '0;
                redir_c  = 1'b1;
                // Only interrupts are vectored; exceptions always land on the base.
                if (irq_q && csr_rdata[1:0] == 2'b01) begin
                    redirect_pc_d = base + VEC_OFFSET;
                end else begin
                    redirect_pc_d = base;
                end
                state_d = IDLE;
            end
            R_STAT: begin
                mstatus_upd[3]     = csr_rdata[7];
                mstatus_upd[7]     = 1'b1;
                mstatus_upd[12:11] = 2'b11;
                we_c     = 1'b1;
                csr_addr = ADDR_MSTATUS;
                csr_data = mstatus_upd;
                mie_d    = csr_rdata[7];
                state_d  = R_EPC;
            end
            R_EPC: begin
                csr_addr      = ADDR_MEPC;
                csr_data      = '0;
                redir_c       = 1'b1;
                redirect_pc_d = base;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are masked during rst so a reset edge never commits a CSR write.
    assign csr_write_en   = we_c && !rst;
    assign stall          = stall_c && !rst;
    assign redirect_valid = redir_c && !rst;
    assign redirect_pc    = redirect_valid ? redirect_pc_d : redirect_pc_q;
    assign pipe_csr_rdata = csr_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mie_q         <= 1'b0;
            irq_q         <= 1'b0;
            epc_q         <= '0;
            cause_q       <= '0;
            tval_q        <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            mie_q         <= mie_d;
            irq_q         <= irq_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            tval_q        <= tval_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Scoreboard bench for riscv_trap_ctrl: stimulus pushes expected CSR writes and
// redirects (with their cycle) into a queue, a negedge monitor pops and compares.
module tb_riscv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, mret_valid, irq_ext, pipe_csr_we;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval, cur_pc, pipe_csr_addr, pipe_csr_wdata;
    logic [31:0] pipe_csr_rdata, csr_addr, csr_data, csr_rdata, redirect_pc;
    logic        csr_write_en, stall, redirect_valid;

    riscv_trap_ctrl #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid), .irq_ext(irq_ext), .cur_pc(cur_pc),
        .pipe_csr_we(pipe_csr_we), .pipe_csr_addr(pipe_csr_addr),
        .pipe_csr_wdata(pipe_csr_wdata), .pipe_csr_rdata(pipe_csr_rdata),
        .csr_write_en(csr_write_en), .csr_addr(csr_addr), .csr_data(csr_data),
        .csr_rdata(csr_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // CSR file stand-in: combinational read, write on the clock edge.
    logic [31:0] csr_mem [0:4095];
    assign csr_rdata = csr_mem[csr_addr[11:0]];
    always @(posedge clk) if (csr_write_en) csr_mem[csr_addr[11:0]] <= csr_data;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_redir;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;
    ev_t exp_q[$];

    // Architectural reference state.
    logic [31:0] m_mstatus = 0, m_mtvec = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;
    logic [31:0] m_last_redir = 0;
    bit          m_mie = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_event(input bit is_redir, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got redir=%0d addr=0x%08h data=0x%08h at cycle %0d, expected none",
                     is_redir, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_redir != is_redir || e.data !== data || e.cyc != cyc ||
                (!is_redir && e.addr !== addr)) begin
                n_errors++;
                $display("FAIL event: got redir=%0d addr=0x%08h data=0x%08h cyc=%0d expected redir=%0d addr=0x%08h data=0x%08h cyc=%0d",
                         is_redir, addr, data, cyc, e.is_redir, e.addr, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (csr_write_en)   check_event(1'b0, csr_addr, csr_data);
        if (redirect_valid) check_event(1'b1, 32'h0, redirect_pc);
    end

    function automatic void push_ev(input bit r, input logic [31:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.is_redir = r; e.addr = a; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        case (a)
            32'h300: begin m_mstatus = d; m_mie = d[3]; end
            32'h305: m_mtvec  = d;
            32'h341: m_mepc   = d;
            32'h342: m_mcause = d;
            32'h343: m_mtval  = d;
            default: ;
        endcase
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        exc_valid = 0; mret_valid = 0; irq_ext = 0; pipe_csr_we = 0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("stall_idle", {31'b0, stall}, 32'h0);
        check("redirect_pc_hold", redirect_pc, m_last_redir);
        step();
    endtask

    task automatic pipe_write(input logic [31:0] a, input logic [31:0] d);
        pipe_csr_we = 1; pipe_csr_addr = a; pipe_csr_wdata = d;
        push_ev(0, a, d, cyc);
        model_write(a, d);
        @(negedge clk);
        check("stall_pipe_write", {31'b0, stall}, 32'h0);
        step();
        pipe_csr_we = 0;
    endtask

    // Exception (is_irq=0) or interrupt (is_irq=1). noise raises every other
    // event source plus a pipeline write to 0x340 in the same cycles.
    task automatic trap(input bit is_irq, input logic [3:0] cause, input logic [31:0] pc,
                        input logic [31:0] tval, input bit noise, input bit gap);
        int t;
        logic [31:0] e_cause, e_tval, target;
        if (is_irq) begin
            irq_ext = 1; cur_pc = pc;
            e_cause = 32'h8000000B; e_tval = 0;
        end else begin
            exc_valid = 1; exc_cause = cause; exc_pc = pc; exc_tval = tval;
            e_cause = {28'h0, cause}; e_tval = tval;
        end
        if (noise) begin
            mret_valid = 1; irq_ext = 1;
            pipe_csr_we = 1; pipe_csr_addr = 32'h340; pipe_csr_wdata = $urandom;
        end
        t = cyc;
        m_mepc = pc; m_mcause = e_cause; m_mtval = e_tval;
        push_ev(0, 32'h341, pc, t + 1);
        push_ev(0, 32'h342, e_cause, t + 2);
        push_ev(0, 32'h343, e_tval, t + 3);
        m_mstatus = (m_mstatus & ~32'h1888) | (m_mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
        m_mie = 0;
        push_ev(0, 32'h300, m_mstatus, t + 4);
        target = m_mtvec & ~32'h3;
        if (is_irq && m_mtvec[1:0] == 2'b01) target = target + 44;
        push_ev(1, 0, target, t + 5);
        m_last_redir = target;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stall_trap", {31'b0, stall}, 32'h1);
            step();
        end
        clear_inputs();
        if (gap) idle_check();
    endtask

    task automatic mret(input bit gap);
        int t;
        t = cyc;
        mret_valid = 1;
        m_mie = m_mstatus[7];
        m_mstatus = (m_mstatus & ~32'h1888) | (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
        push_ev(0, 32'h300, m_mstatus, t + 1);
        push_ev(1, 0, m_mepc & ~32'h3, t + 2);
        m_last_redir = m_mepc & ~32'h3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_mret", {31'b0, stall}, 32'h1);
            step();
        end
        clear_inputs();
        if (gap) idle_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] a, d;
        for (int i = 0; i < 4096; i++) csr_mem[i] = 0;
        rst = 1; clear_inputs();
        exc_cause = 0; exc_pc = 0; exc_tval = 0; cur_pc = 0;
        pipe_csr_addr = 0; pipe_csr_wdata = 0;
        step(); step();
        @(negedge clk);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check("reset_csr_write_en", {31'b0, csr_write_en}, 32'h0);
        step();
        rst = 0;
        idle_check();

        // Ecall then mret
        pipe_write(32'h305, 32'h100);
        pipe_write(32'h300, 32'h8);
        trap(0, 4'd11, 32'h40, 32'h0, 0, 1);
        mret(1);

        // Vectored interrupt
        pipe_write(32'h305, 32'h201);
        pipe_write(32'h300, 32'h8);
        trap(1, 4'd0, 32'h80, 32'h0, 0, 1);

        // Masked interrupt: MIE is 0 after the trap
        irq_ext = 1;
        for (int k = 0; k < 10; k++) idle_check();
        irq_ext = 0;

        // Deferred interrupt: pipeline write in the same cycle holds it off
        pipe_write(32'h300, 32'h8);
        irq_ext = 1; cur_pc = 32'h1234;
        pipe_write(32'h340, 32'hCAFE);
        trap(1, 4'd0, 32'h1234, 32'h0, 0, 1);

        // Priority: all sources high plus a pipeline write to 0x340
        pipe_write(32'h300, 32'h8);
        pipe_write(32'h340, 32'h5A5A);
        trap(0, 4'd2, 32'h300, 32'hDEAD_BEEF, 1, 1);
        check("priority_0x340_kept", csr_mem[12'h340], 32'h5A5A);

        // Reset mid-sequence at T+2
        exc_valid = 1; exc_cause = 4'd3; exc_pc = 32'h500; exc_tval = 32'h0;
        t = cyc;
        m_mepc = 32'h500;
        push_ev(0, 32'h341, 32'h500, t + 1);
        step(); step();
        rst = 1;
        step();
        rst = 0; clear_inputs();
        m_mie = 0; m_last_redir = 0;
        idle_check();
        check("rst_mid_mcause_kept", csr_mem[12'h342], m_mcause);
        check("rst_mid_mtval_kept", csr_mem[12'h343], m_mtval);

        // Randomised mix, including back-to-back events after a redirect
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 4))
                0: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h300;
                        1: a = 32'h305;
                        2: a = 32'h341;
                        default: a = 32'h340;
                    endcase
                    d = $urandom;
                    pipe_write(a, d);
                end
                1: begin
                    case ($urandom_range(0, 2))
                        0: d = 2;
                        1: d = 3;
                        default: d = 11;
                    endcase
                    trap(0, d[3:0], $urandom, $urandom, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1);
                end
                2: mret($urandom_range(0, 1) == 1);
                3: begin
                    if (m_mie) begin
                        trap(1, 4'd0, $urandom, 32'h0, 0, $urandom_range(0, 1) == 1);
                    end else begin
                        irq_ext = 1; cur_pc = $urandom;
                        idle_check();
                        irq_ext = 0;
                    end
                end
                default: idle_check();
            endcase
        end
        idle_check();
        step();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL events_outstanding: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
